// File: rtl/epu_fetch_pkg.sv
// epu_fetch_pkg
//   Shared definitions for the EPU block-fetch engine.
//   - fetch_state_e : run-control FSM states
//   - RD_LAT        : SRAM read latency in cycles (data valid the cycle after mem_read)
//   - idx_width()   : width of a block index, never less than 1 bit
package epu_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } fetch_state_e;

  localparam int RD_LAT = 1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/epu_fetch_fifo.sv
// epu_fetch_fifo
//   Small synchronous FIFO used as the output skid buffer of the fetch engine.
//   Head entry is presented combinationally so the stream word is visible in
//   the same cycle the FIFO becomes non-empty. Entries are individual
//   registers with async reset so the head reads 0 while in reset.
// Ports:
//   clk, rst (async, active low)
//   push, push_data  : write one entry (caller guarantees not full)
//   pop              : remove head entry (ignored when empty)
//   head_data        : current head entry
//   empty            : no entries stored
//   count            : number of stored entries (used for read credits)
module epu_fetch_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] entries [DEPTH];
  logic             pop_ok;

  assign pop_ok = pop && (count_reg != '0);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg <= push_data;
        end
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop_ok) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (!push && pop_ok) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  assign head_data = entries[rd_ptr_reg];
  assign empty     = (count_reg == '0);
  assign count     = count_reg;

endmodule

// File: rtl/epu_blk_fetch.sv
// epu_blk_fetch
//   Block-fetch engine: on start, reads blk_cnt blocks of WORDS_PER_BLK words
//   from SRAM beginning at base_addr and streams them out over valid/ready,
//   tagging each word with its block index and an end-of-block flag.
//   Reads are only issued while the skid FIFO plus the in-flight read leave
//   room, so SRAM data can always be pushed the cycle it arrives.
// Optional feature (macro EPU_FETCH_CKSUM_EN): per-block XOR checksum
//   outputs cksum / cksum_valid, accumulated on stream transfers.
// Ports:
//   clk, rst (async, active low)
//   start, base_addr, blk_cnt              : run request (sampled in IDLE)
//   mem_read, mem_addr, mem_rdata          : 1-cycle-latency SRAM read port
//   out_valid, out_ready, out_data,
//   out_last, out_blk_idx                  : output stream
//   busy, done                             : run status
//   cksum, cksum_valid                     : only with EPU_FETCH_CKSUM_EN
module epu_blk_fetch
  import epu_fetch_pkg::*;
#(
  parameter  int DATA_W        = 128,
  parameter  int ADDR_W        = 12,
  parameter  int BLOCK_NUM     = 64,
  parameter  int WORDS_PER_BLK = 16,
  parameter  int FIFO_DEPTH    = 4,
  localparam int CNT_W         = $clog2(BLOCK_NUM + 1),
  localparam int IDX_W         = idx_width(BLOCK_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  blk_cnt,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [IDX_W-1:0]  out_blk_idx,
  output logic              busy,
  output logic              done
`ifdef EPU_FETCH_CKSUM_EN
  ,
  output logic [DATA_W-1:0] cksum,
  output logic              cksum_valid
`endif
);

  localparam int WORD_W = $clog2(WORDS_PER_BLK);
  localparam int LIN_W  = CNT_W + WORD_W;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRED_W = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam int ENT_W  = DATA_W + 1 + IDX_W;

  fetch_state_e      state_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] last_addr_reg;
  logic [CNT_W-1:0]  blk_cnt_reg;
  logic [CNT_W-1:0]  blk_reg;
  logic [WORD_W-1:0] word_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              inflight_reg;
  logic              inflight_last_reg;
  logic [IDX_W-1:0]  inflight_idx_reg;

  logic [CNT_W-1:0]  start_cnt;
  logic [LIN_W-1:0]  lin_idx;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_last;
  logic              rd_final;
  logic [CRED_W-1:0] credit_used;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_empty;
  logic              xfer;
  logic [ENT_W-1:0]  fifo_push_data;
  logic [ENT_W-1:0]  fifo_head;

  assign start_cnt = (blk_cnt > CNT_W'(BLOCK_NUM)) ? CNT_W'(BLOCK_NUM) : blk_cnt;

  // Blocks are contiguous, so {blk, word} is the linear word offset from base.
  assign lin_idx  = {blk_reg, word_reg};
  assign rd_addr  = base_reg + ADDR_W'(lin_idx);
  assign rd_last  = (word_reg == WORD_W'(WORDS_PER_BLK - 1));
  assign rd_final = rd_last && (blk_reg == blk_cnt_reg - CNT_W'(1));

  // Every issued read owns a FIFO slot until it is popped downstream.
  assign credit_used = CRED_W'(fifo_count) + CRED_W'(inflight_reg);
  assign mem_read    = (state_reg == ST_FETCH) && (credit_used < CRED_W'(FIFO_DEPTH));
  assign mem_addr    = mem_read ? rd_addr : last_addr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      base_reg      <= '0;
      last_addr_reg <= '0;
      blk_cnt_reg   <= '0;
      blk_reg       <= '0;
      word_reg      <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (start) begin
            base_reg    <= base_addr;
            blk_cnt_reg <= start_cnt;
            blk_reg     <= '0;
            word_reg    <= '0;
            if (start_cnt == '0) begin
              state_reg <= ST_FIN;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_FETCH;
              busy_reg  <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (mem_read) begin
            last_addr_reg <= rd_addr;
            // WORDS_PER_BLK is a power of two: word wraps to 0 by overflow.
            word_reg <= word_reg + WORD_W'(1);
            if (rd_last) begin
              blk_reg <= blk_reg + CNT_W'(1);
            end
            if (rd_final) begin
              state_reg <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!inflight_reg && fifo_empty) begin
            state_reg <= ST_FIN;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        ST_FIN: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Tags travel alongside the read so they line up with the returning data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      inflight_idx_reg  <= '0;
    end else begin
      inflight_reg <= mem_read;
      if (mem_read) begin
        inflight_last_reg <= rd_last;
        inflight_idx_reg  <= blk_reg[IDX_W-1:0];
      end
    end
  end

  assign fifo_push_data = {mem_rdata, inflight_last_reg, inflight_idx_reg};

  epu_fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg),
    .push_data (fifo_push_data),
    .pop       (xfer),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign xfer      = out_valid && out_ready;
  assign {out_data, out_last, out_blk_idx} = fifo_head;
  assign busy      = busy_reg;
  assign done      = done_reg;

`ifdef EPU_FETCH_CKSUM_EN
  logic [DATA_W-1:0] cksum_acc_reg;
  logic [DATA_W-1:0] cksum_hold_reg;
  logic [DATA_W-1:0] cksum_cur;

  assign cksum_cur   = cksum_acc_reg ^ out_data;
  assign cksum_valid = xfer && out_last;
  assign cksum       = cksum_valid ? cksum_cur : cksum_hold_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cksum_acc_reg  <= '0;
      cksum_hold_reg <= '0;
    end else if ((state_reg == ST_IDLE) && start) begin
      cksum_acc_reg <= '0;
    end else if (xfer) begin
      if (out_last) begin
        cksum_acc_reg  <= '0;
        cksum_hold_reg <= cksum_cur;
      end else begin
        cksum_acc_reg <= cksum_cur;
      end
    end
  end
`else
  // Checksum outputs are not built in this configuration.
`endif

endmodule

// File: tb/tb_epu_blk_fetch.sv
module tb_epu_blk_fetch;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 12;
  localparam int NWORDS = 1 << ADDR_W;
  localparam int WPB    = 16;
  localparam int MAXBLK = 64;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [6:0]        blk_cnt;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [5:0]        out_blk_idx;
  logic              busy;
  logic              done;
`ifdef EPU_FETCH_CKSUM_EN
  logic [DATA_W-1:0] cksum;
  logic              cksum_valid;
  logic [DATA_W-1:0] last_cksum;
`endif

  int checks   = 0;
  int failures = 0;
  int max_out;

  logic [DATA_W-1:0] sram [NWORDS];

  epu_blk_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .blk_cnt     (blk_cnt),
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_blk_idx (out_blk_idx),
    .busy        (busy),
    .done        (done)
`ifdef EPU_FETCH_CKSUM_EN
    ,
    .cksum       (cksum),
    .cksum_valid (cksum_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_read) mem_rdata <= sram[mem_addr];
  end

  task automatic fill_sram();
    for (int a = 0; a < NWORDS; a++) begin
      sram[a] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({mem_read, mem_addr, out_valid, out_data, out_last, out_blk_idx, busy, done} !== '0) begin
      failures++;
      $display("FAIL %s: outputs not zero rd=%0b addr=%0h v=%0b data=%0h last=%0b idx=%0d busy=%0b done=%0b",
               tag, mem_read, mem_addr, out_valid, out_data, out_last, out_blk_idx, busy, done);
    end
  endtask

  // One complete run with the reference model: expected words are the SRAM
  // contents at (base + i) mod 2^ADDR_W for i in 0 .. blocks*WPB-1.
  task automatic do_run(input int base, input int cnt, input int ready_pct,
                        input bit check_latency, input int poke_cyc);
    int nblk;
    int n;
    int issued;
    int outn;
    int cyc;
    int first_valid;
    int first_read;
    int outstanding;
    int budget;
    bit done_seen;
    bit exp_read;
    bit prev_stall;
    logic [DATA_W-1:0] held_data;
    logic              held_last;
    logic [5:0]        held_idx;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] q_data [$];
    bit                q_last [$];
    int                q_idx  [$];
    logic [DATA_W-1:0] ed;
    bit                el;
    int                ei;
`ifdef EPU_FETCH_CKSUM_EN
    logic [DATA_W-1:0] acc;
    acc = '0;
`endif
    nblk = (cnt > MAXBLK) ? MAXBLK : cnt;
    n = nblk * WPB;
    for (int i = 0; i < n; i++) begin
      q_data.push_back(sram[(base + i) % NWORDS]);
      q_last.push_back((i % WPB) == WPB - 1);
      q_idx.push_back(i / WPB);
    end
    issued = 0; outn = 0; cyc = 0; first_valid = -1; first_read = -1;
    done_seen = 0; prev_stall = 0; max_out = 0;
    held_data = '0; held_last = 0; held_idx = '0;
    budget = n * 20 + 50;

    @(negedge clk);
    base_addr = ADDR_W'(base);
    blk_cnt   = 7'(cnt);
    start     = 1'b1;
    out_ready = 1'b0;

    while (!done_seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke_cyc);
      if (start) begin
        base_addr = ~ADDR_W'(base);
        blk_cnt   = 7'd5;
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      #1;
      outstanding = issued - outn;
      if (outstanding > max_out) max_out = outstanding;

      // Read strobe must follow the credit rule exactly.
      exp_read = busy && (issued < n) && (outstanding < DEPTH);
      checks++;
      if (mem_read !== exp_read) begin
        failures++;
        $display("FAIL read_issue cyc=%0d: got %0b expected %0b (outstanding=%0d)",
                 cyc, mem_read, exp_read, outstanding);
      end
      if (mem_read) begin
        exp_addr = ADDR_W'(base + issued);
        checks++;
        if (mem_addr !== exp_addr) begin
          failures++;
          $display("FAIL read_addr: got %0h expected %0h", mem_addr, exp_addr);
        end
        if (first_read < 0) first_read = cyc;
        issued++;
      end

      if (prev_stall) begin
        checks++;
        if (!out_valid || out_data !== held_data || out_last !== held_last || out_blk_idx !== held_idx) begin
          failures++;
          $display("FAIL stall_stable: got v=%0b data=%0h last=%0b idx=%0d expected data=%0h last=%0b idx=%0d",
                   out_valid, out_data, out_last, out_blk_idx, held_data, held_last, held_idx);
        end
      end

      if (out_valid && first_valid < 0) first_valid = cyc;

      if (out_valid && out_ready) begin
        if (q_data.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_word: got %0h expected none", out_data);
        end else begin
          ed = q_data.pop_front();
          el = q_last.pop_front();
          ei = q_idx.pop_front();
          $display("xfer word=%0d data=%0h last=%0b idx=%0d", outn, out_data, out_last, out_blk_idx);
          checks++;
          if (out_data !== ed) begin
            failures++;
            $display("FAIL out_data word %0d: got %0h expected %0h", outn, out_data, ed);
          end
          checks++;
          if (out_last !== el) begin
            failures++;
            $display("FAIL out_last word %0d: got %0b expected %0b", outn, out_last, el);
          end
          checks++;
          if (out_blk_idx !== 6'(ei)) begin
            failures++;
            $display("FAIL out_blk_idx word %0d: got %0d expected %0d", outn, out_blk_idx, ei);
          end
`ifdef EPU_FETCH_CKSUM_EN
          acc = acc ^ ed;
          checks++;
          if (cksum_valid !== el) begin
            failures++;
            $display("FAIL cksum_valid word %0d: got %0b expected %0b", outn, cksum_valid, el);
          end
          if (el) begin
            checks++;
            if (cksum !== acc) begin
              failures++;
              $display("FAIL cksum block %0d: got %0h expected %0h", ei, cksum, acc);
            end
            last_cksum = cksum;
            acc = '0;
          end
`endif
        end
        outn++;
      end else begin
`ifdef EPU_FETCH_CKSUM_EN
        checks++;
        if (cksum_valid !== 1'b0) begin
          failures++;
          $display("FAIL cksum_valid_idle: got %0b expected 0", cksum_valid);
        end
`endif
      end

      prev_stall = out_valid && !out_ready;
      held_data  = out_data;
      held_last  = out_last;
      held_idx   = out_blk_idx;

      if (done) begin
        done_seen = 1;
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL busy_at_done: got %0b expected 0", busy);
        end
      end
    end
    start = 1'b0;

    $display("run base=%0h cnt=%0d ready=%0d%%: words=%0d reads=%0d cycles=%0d",
             base, cnt, ready_pct, outn, issued, cyc);
    checks++;
    if (!done_seen) begin
      failures++;
      $display("FAIL done_timeout: got no done in %0d cycles expected one", budget);
    end
    checks++;
    if (outn != n) begin
      failures++;
      $display("FAIL word_count: got %0d expected %0d", outn, n);
    end
    checks++;
    if (issued != n) begin
      failures++;
      $display("FAIL read_count: got %0d expected %0d", issued, n);
    end
    if (check_latency) begin
      checks++;
      if (first_read != 1) begin
        failures++;
        $display("FAIL first_read_cycle: got %0d expected 1", first_read);
      end
      checks++;
      if (first_valid != 3) begin
        failures++;
        $display("FAIL first_valid_cycle: got %0d expected 3", first_valid);
      end
    end
    if (n == 0) begin
      checks++;
      if (cyc > 2) begin
        failures++;
        $display("FAIL zero_run_done: got cycle %0d expected <= 2", cyc);
      end
    end
    // Idle afterwards: single done pulse, busy low, nothing streaming.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({done, busy, out_valid, mem_read} !== 4'b0) begin
        failures++;
        $display("FAIL post_run_idle: got done=%0b busy=%0b v=%0b rd=%0b expected all 0",
                 done, busy, out_valid, mem_read);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("after_reset_release");
  endtask

  task automatic test_full_run();
    do_run(0, 64, 100, 1, 0);
  endtask

  task automatic test_wrap();
    do_run('hFF8, 2, 100, 1, 0);
  endtask

  task automatic test_backpressure();
    do_run($urandom_range(0, NWORDS - 1), 3, 30, 0, 0);
    checks++;
    if (max_out != DEPTH) begin
      failures++;
      $display("FAIL credit_fill: got max outstanding %0d expected %0d", max_out, DEPTH);
    end
  endtask

  task automatic test_zero_and_clamp();
    do_run($urandom_range(0, NWORDS - 1), 0, 100, 0, 0);
    do_run($urandom_range(0, NWORDS - 1), 100, 100, 1, 0);
  endtask

  task automatic test_abort_restart();
    int outn;
    int cyc;
    @(negedge clk);
    base_addr = ADDR_W'($urandom_range(0, NWORDS - 1));
    blk_cnt   = 7'd3;
    start     = 1'b1;
    out_ready = 1'b1;
    outn = 0;
    cyc  = 0;
    while (outn < 20 && cyc < 200) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      #1;
      if (out_valid) outn++;
    end
    checks++;
    if (outn != 20) begin
      failures++;
      $display("FAIL abort_reach_word20: got %0d expected 20", outn);
    end
    rst = 1'b0;
    #1;
    check_all_zero("abort_reset");
`ifdef EPU_FETCH_CKSUM_EN
    checks++;
    if ({cksum, cksum_valid} !== '0) begin
      failures++;
      $display("FAIL abort_reset_cksum: got %0h/%0b expected 0", cksum, cksum_valid);
    end
`endif
    @(negedge clk);
    #1;
    check_all_zero("abort_reset_hold");
    @(negedge clk);
    rst = 1'b1;
    do_run($urandom_range(0, NWORDS - 1), 1, 100, 1, 5);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      do_run($urandom_range(0, NWORDS - 1), $urandom_range(1, 5), $urandom_range(20, 100), 0, 0);
    end
  endtask

`ifdef EPU_FETCH_CKSUM_EN
  task automatic test_cksum();
    int base;
    int odd;
    base = $urandom_range(0, NWORDS - 1);
    odd  = $urandom_range(0, WPB - 1);
    for (int i = 0; i < WPB; i++) begin
      sram[(base + i) % NWORDS] = (i == odd) ? DATA_W'(3) : DATA_W'(1);
    end
    do_run(base, 1, 60, 0, 0);
    checks++;
    if (last_cksum !== DATA_W'(2)) begin
      failures++;
      $display("FAIL cksum_pattern: got %0h expected 2", last_cksum);
    end
  endtask
`endif

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    blk_cnt   = '0;
    out_ready = 1'b0;
    fill_sram();
    test_reset();
    test_full_run();
    test_wrap();
    test_backpressure();
    test_zero_and_clamp();
    test_abort_restart();
    fill_sram();
    test_back_to_back();
`ifdef EPU_FETCH_CKSUM_EN
    test_cksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/epu_blk_fetch.md
Name: epu_blk_fetch

Overview:
Parametrised block-fetch engine for the EPU datapath. On `start` it reads `blk_cnt` blocks of WORDS_PER_BLK words each from the EPU SRAM, starting at `base_addr`, over the 1-cycle-latency read port. It streams the words to the downstream EPU algorithm stage over a valid/ready interface with full backpressure.
- Successor to the fixed 64-block, 16-word, 128-bit fetch front-end.
- Adds runtime block count, base address, downstream backpressure and block-boundary tagging.

Parameters:
DATA_W, 128, SRAM word / stream width in bits
ADDR_W, 12, SRAM word-address width
BLOCK_NUM, 64, maximum blocks per run; sizes `blk_cnt`
WORDS_PER_BLK, 16, words per block; power of 2, ≥2
FIFO_DEPTH, 4, output skid FIFO entries; power of 2, ≥2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle run request, sampled in IDLE only
base_addr  in  ADDR_W  first word address, latched at start
blk_cnt  in  $clog2(BLOCK_NUM+1)  blocks to fetch, latched at start; values >BLOCK_NUM clamp to BLOCK_NUM
mem_read  out  1  SRAM read strobe
mem_addr  out  ADDR_W  SRAM word address
mem_rdata  in  DATA_W  SRAM data, valid the cycle after the mem_read cycle
out_valid  out  1  stream word valid
out_ready  in  1  downstream accept
out_data  out  DATA_W  stream word
out_last  out  1  word is last of its block
out_blk_idx  out  $clog2(BLOCK_NUM)  block index of the current word
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse when the run completes

Behaviour:
- Reset values (async, rst=0): all outputs 0, FSM=IDLE, FIFO empty, counters 0. Reset mid-run aborts immediately; discard in-flight read data.
- FSM states:
  - IDLE: on start, latch base/count. If clamped count = 0, go to FIN. Otherwise go to FETCH.
  - FETCH: issue reads. After the last read is issued, go to DRAIN.
  - DRAIN: wait until the in-flight read has landed and the FIFO is empty, then go to FIN.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- start outside IDLE is ignored.
- Read issue:
  - mem_read=1 in FETCH when (fifo_count + inflight) < FIFO_DEPTH. inflight is 0 or 1.
  - Data captured from mem_rdata one cycle later is pushed into the FIFO unconditionally. The credit rule guarantees no overflow.
  - Peak throughput is 1 word/clk with out_ready held high.
- Addressing:
  - mem_addr = base_addr + blk*WORDS_PER_BLK + word, modulo 2^ADDR_W (wrap silently).
  - word wraps at WORDS_PER_BLK-1 and increments blk.
  - mem_addr holds its last value when mem_read=0.
- Stream:
  - out_valid = FIFO non-empty. out_data, out_last and out_blk_idx are stored per entry.
  - Transfer on out_valid & out_ready. out_data and its tags must stay stable while out_valid=1 and out_ready=0.
- Latency: first out_valid occurs 3 cycles after the start cycle (IDLE→FETCH, read, capture/push).
- Simultaneous FIFO push and pop: count unchanged, no data lost. Full FIFO: reads stall, no push is lost.
- Word order out equals address order. Exactly blk_cnt*WORDS_PER_BLK words per run.

Optional Feature:
Macro: EPU_FETCH_CKSUM_EN
- Defined: adds outputs `cksum` [DATA_W-1:0] and `cksum_valid`.
  - cksum is the XOR of all words of a block, accumulated on stream transfer.
  - cksum_valid pulses for one cycle on the cycle the out_last word transfers; cksum holds that block's value.
  - The accumulator resets to 0 at each block start and on rst.
- Not defined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package `epu_fetch_pkg`: FSM state enum (IDLE, FETCH, DRAIN, FIN) and the read-latency constant RD_LAT=1.
- Sub-module `epu_fetch_fifo`: synchronous FIFO, width DATA_W + 1 + $clog2(BLOCK_NUM), depth FIFO_DEPTH, with a count output used for credits.

Test Plan:
1. Defaults, base=0x000, blk_cnt=64, out_ready=1 → 1024 words out in address order; out_last on every 16th word; out_blk_idx 0..63; done exactly once; busy low after done.
2. base=0xFF8, blk_cnt=2 → addresses 0xFF8..0xFFF, 0x000..0x017 (wrap); 32 words out; out_blk_idx switches to 1 at word 16.
3. blk_cnt=3, out_ready toggled randomly, 30% high → mem_read stalls once 4 entries are committed; no word lost or duplicated; out_data stable during stall.
4. blk_cnt=0 → no mem_read, done pulse within 2 cycles; blk_cnt=100 with BLOCK_NUM=64 → 64 blocks fetched.
5. rst low at word 20 of a run, then release and start again with blk_cnt=1 → all outputs 0 during reset; new run delivers exactly 16 words; start pulsed while busy is ignored.
6. With EPU_FETCH_CKSUM_EN, a block of 16 words all 0x…01 except one 0x…03 → cksum=0x…02 with cksum_valid on the last-word transfer.
